// File: rtl/jpeg_quantize_array.sv
// JPEG 8x8 block quantizer: one coefficient per cycle through a shared reciprocal multiplier.
// Optional macro QUANT_PIPE_EN adds a register stage between the multiplier and round/clamp.
module jpeg_quantize_array #(
    parameter int USE_LUMA = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2047:0] pixels,
    output logic [1023:0] q_result,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] LUMA_Q [64] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam logic [7:0] CHROMA_Q [64] = '{
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

    // Reciprocals round(2^20 / Q) so the divide becomes a multiply and a 36-bit shift.
    function automatic logic [64*21-1:0] build_rom();
        logic [64*21-1:0] rom;
        int q;
        rom = '0;
        for (int i = 0; i < 64; i++) begin
            q = (USE_LUMA != 0) ? int'(LUMA_Q[i]) : int'(CHROMA_Q[i]);
            rom[i*21 +: 21] = 21'((1048576 + q / 2) / q);
        end
        return rom;
    endfunction

    localparam logic [64*21-1:0] RECIP_ROM = build_rom();

    state_t         state_q, state_d;
    logic [6:0]     idx_q, idx_d;
    logic [2047:0]  cap_q, cap_d;
    logic [1023:0]  res_q, res_d;
    logic           done_q, done_d;

    logic [5:0]         rd_idx;
    logic [31:0]        coef;
    logic [20:0]        recip;
    logic signed [53:0] prod;
    logic               issue;
    logic signed [53:0] rnd_in;
    logic [53:0]        mag;
    logic [53:0]        mag_sum;
    logic [17:0]        rounded;
    logic [15:0]        wr_val;
    logic               wr_en;
    logic [5:0]         wr_idx;

    always_comb begin
        rd_idx = idx_q[5:0];
        coef   = cap_q[rd_idx*32 +: 32];
        recip  = RECIP_ROM[rd_idx*21 +: 21];
        prod   = $signed({{22{coef[31]}}, coef}) * $signed({33'd0, recip});
        issue  = (state_q == RUN) && !idx_q[6];
    end

`ifdef QUANT_PIPE_EN
    logic signed [53:0] prod_q, prod_d;
    logic               vld_q, vld_d;
    logic [5:0]         widx_q, widx_d;

    always_comb begin
        prod_d = prod;
        vld_d  = issue;
        widx_d = rd_idx;
        rnd_in = prod_q;
        wr_en  = vld_q;
        wr_idx = widx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
            widx_q <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
            widx_q <= widx_d;
        end
    end
`else
    always_comb begin
        rnd_in = prod;
        wr_en  = issue;
        wr_idx = rd_idx;
    end
`endif

    // Round half away from zero on the magnitude, then restore sign and saturate to int16.
    always_comb begin
        mag     = rnd_in[53] ? $unsigned(-rnd_in) : $unsigned(rnd_in);
        mag_sum = mag + 54'h8_0000_0000;
        rounded = 18'(mag_sum >> 36);
        if (!rnd_in[53]) begin
            wr_val = (rounded > 18'd32767) ? 16'h7FFF : rounded[15:0];
        end else begin
            wr_val = (rounded > 18'd32768) ? 16'h8000 : (~rounded[15:0] + 16'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (wr_en && (wr_idx == 6'd63)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d  = issue ? idx_q + 7'd1 : idx_q;
        cap_d  = cap_q;
        res_d  = res_q;
        done_d = (state_q == DONE);
        if ((state_q == IDLE) && start) begin
            idx_d = '0;
            cap_d = pixels;
        end
        if (wr_en) begin
            res_d[wr_idx*16 +: 16] = wr_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            cap_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cap_q  <= cap_d;
            res_q  <= res_d;
            done_q <= done_d;
        end
    end

    assign q_result = res_q;
    assign done     = done_q;

endmodule

// File: tb/tb_jpeg_quantize_array.sv
// Testbench for jpeg_quantize_array: luma and chroma instances side by side, checked
// against an arithmetic reference of the reciprocal/round/clamp rule.
module tb_jpeg_quantize_array;

`ifdef QUANT_PIPE_EN
    localparam int LAT = 66;
`else
    localparam int LAT = 65;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2047:0] pixels = '0;
    logic [1023:0] q_l, q_c;
    logic          done_l, done_c;

    int checks = 0;
    int errors = 0;

    jpeg_quantize_array #(.USE_LUMA(1)) dut_l (
        .clk(clk), .rst(rst), .start(start), .pixels(pixels),
        .q_result(q_l), .done(done_l)
    );

    jpeg_quantize_array #(.USE_LUMA(0)) dut_c (
        .clk(clk), .rst(rst), .start(start), .pixels(pixels),
        .q_result(q_c), .done(done_c)
    );

    always #5 clk = ~clk;

    int luma_q [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    int chroma_q [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    typedef struct {
        logic [31:0] coef;
        int          slot;
        bit          luma;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs [10];

    // Quantize coef/q: value scaled by round(2^20/q), then coef*R/2^36 rounded half away from zero.
    function automatic logic [15:0] ref_q(input logic [31:0] c, input int q);
        longint recip, p, m, r;
        recip = (64'sd2097152 + longint'(q)) / (2 * longint'(q));
        p = longint'($signed(c)) * recip;
        m = (p < 0) ? -p : p;
        r = (m + (64'sd1 <<< 35)) >>> 36;
        if (p < 0) r = -r;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_output(input string name, input logic [2047:0] blk);
        logic [1023:0] exp_l, exp_c;
        int bad_l, bad_c;
        bad_l = -1;
        bad_c = -1;
        for (int i = 0; i < 64; i++) begin
            exp_l[i*16 +: 16] = ref_q(blk[i*32 +: 32], luma_q[i]);
            exp_c[i*16 +: 16] = ref_q(blk[i*32 +: 32], chroma_q[i]);
        end
        for (int i = 63; i >= 0; i--) begin
            if (q_l[i*16 +: 16] !== exp_l[i*16 +: 16]) bad_l = i;
            if (q_c[i*16 +: 16] !== exp_c[i*16 +: 16]) bad_c = i;
        end
        checks += 2;
        if (bad_l >= 0) begin
            errors++;
            $display("[TB] FAIL %s luma slot %0d actual=%h required=%h", name, bad_l,
                     q_l[bad_l*16 +: 16], exp_l[bad_l*16 +: 16]);
        end
        if (bad_c >= 0) begin
            errors++;
            $display("[TB] FAIL %s chroma slot %0d actual=%h required=%h", name, bad_c,
                     q_c[bad_c*16 +: 16], exp_c[bad_c*16 +: 16]);
        end
    endtask

    // Start a block, scramble inputs after capture, optionally poke start mid-run,
    // and return the number of edges from the start edge until done is seen.
    task automatic apply_stimulus(input logic [2047:0] blk, input bit poke_start, output int lat);
        pixels = blk;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) pixels[i*32 +: 32] = $urandom;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            start = poke_start && (n == 20);
            if (done_l) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        check_eq("latency", 32'(lat), 32'(LAT));
        check_eq("done_chroma_aligned", {31'd0, done_c}, 32'd1);
    endtask

    function automatic logic [31:0] rand_coef();
        int mode;
        mode = int'($urandom_range(0, 2));
        if (mode == 0) return $urandom;
        if (mode == 1) return 32'(int'($urandom_range(0, 20000000)) - 10000000);
        return 32'((int'($urandom_range(0, 2000)) - 1000) <<< 15);
    endfunction

    logic [2047:0] blk;
    int lat;
    bit seen;

    initial begin
        vecs[0] = '{32'h00100000, 0,  1'b1, 16'h0001};
        vecs[1] = '{32'hFFF00000, 0,  1'b1, 16'hFFFF};
        vecs[2] = '{32'h00080000, 0,  1'b1, 16'h0001};
        vecs[3] = '{32'hFFF80000, 0,  1'b1, 16'hFFFF};
        vecs[4] = '{32'h00220000, 0,  1'b0, 16'h0002};
        vecs[5] = '{32'h7FFF0000, 63, 1'b0, 16'h014B};
        vecs[6] = '{32'h80000000, 2,  1'b1, 16'hF333};
        vecs[7] = '{32'h00078000, 0,  1'b1, 16'h0000};
        vecs[8] = '{32'h00180000, 0,  1'b1, 16'h0002};
        vecs[9] = '{32'hFFE80000, 0,  1'b1, 16'hFFFE};

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_done", {30'd0, done_c, done_l}, 32'd0);
        check_eq("reset_q_luma", {31'd0, |q_l}, 32'd0);
        check_eq("reset_q_chroma", {31'd0, |q_c}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        apply_stimulus('0, 1'b0, lat);
        check_output("zero_block", '0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", {30'd0, done_c, done_l}, 32'd0);

        for (int v = 0; v < 10; v++) begin
            blk = '0;
            blk[vecs[v].slot*32 +: 32] = vecs[v].coef;
            apply_stimulus(blk, 1'b0, lat);
            if (vecs[v].luma)
                check_eq($sformatf("vec%0d_luma", v), {16'd0, q_l[vecs[v].slot*16 +: 16]}, {16'd0, vecs[v].expv});
            else
                check_eq($sformatf("vec%0d_chroma", v), {16'd0, q_c[vecs[v].slot*16 +: 16]}, {16'd0, vecs[v].expv});
            check_output($sformatf("vec%0d_block", v), blk);
        end

        // Reset at edge 30 of a block must abort it and clear the results.
        for (int i = 0; i < 64; i++) blk[i*32 +: 32] = rand_coef();
        pixels = blk;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (done_l || done_c) seen = 1'b1;
        end
        check_eq("abort_no_done", {31'd0, seen}, 32'd0);
        check_eq("abort_q_luma", {31'd0, |q_l}, 32'd0);
        check_eq("abort_q_chroma", {31'd0, |q_c}, 32'd0);
        apply_stimulus(blk, 1'b0, lat);
        check_output("after_abort", blk);

        // Back-to-back random blocks, with a stray start pulse mid-run on some.
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < 64; i++) blk[i*32 +: 32] = rand_coef();
            apply_stimulus(blk, (b % 3) == 0, lat);
            check_output($sformatf("rand%0d", b), blk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
